stream_demux_1to4: RTL and testbench

//  - Registered 1-to-4 demultiplexer. Steers one valid/ready data stream to one of four

---
 rtl/stream_demux_1to4_if.sv | 35 +++
 rtl/stream_demux_1to4.sv | 113 +++++++++++
 tb/tb_stream_demux_1to4.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1to4_if.sv
// Handshake bundle for the 1-to-4 stream demultiplexer.
// The master side is the producer and consumers; the slave side is the demux itself.
interface stream_demux_1to4_if #(
  parameter int N  = 32,
  parameter int CW = 16
);

  logic [N-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_data0;
  logic [N-1:0]  out_data1;
  logic [N-1:0]  out_data2;
  logic [N-1:0]  out_data3;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic [CW-1:0] cnt3;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid,
    input  cnt0, cnt1, cnt2, cnt3
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid,
    output cnt0, cnt1, cnt2, cnt3
  );

endinterface

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer.
// Each beat is steered by in_sel into a one-entry register on one of four channels.
// A channel that is full and stalled only blocks beats addressed to itself.
// Optional feature macro: DEMUX_CNT_EN adds a wrapping accepted-beat counter per channel.
module stream_demux_1to4 #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input logic                clk,
  input logic                rst_n,
  stream_demux_1to4_if.slave bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state_q [4];
  logic [N-1:0] data_q  [4];
  logic [3:0]   full;
  logic [3:0]   push;
  logic [3:0]   pop;
  logic         in_ready;

  // Decode which channel registers currently hold a beat.
  always_comb begin
    full = '0;
    for (int k = 0; k < 4; k++) begin
      full[k] = (state_q[k] == FULL);
    end
  end

  // Only the addressed channel decides acceptance, so one stalled consumer cannot block the others.
  assign in_ready = ~full[bus.in_sel] | bus.out_ready[bus.in_sel];

  // Route the accepted beat to exactly one channel.
  always_comb begin
    push = '0;
    for (int k = 0; k < 4; k++) begin
      push[k] = bus.in_valid & in_ready & (bus.in_sel == 2'(k));
    end
  end

  assign pop = full & bus.out_ready;

  // Per-channel EMPTY/FULL state; a simultaneous pop and push keeps the channel full with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        case (state_q[k])
          EMPTY: begin
            if (push[k]) state_q[k] <= FULL;
          end
          FULL: begin
            if (!push[k] && pop[k]) state_q[k] <= EMPTY;
          end
          default: state_q[k] <= EMPTY;
        endcase
      end
    end
  end

  // Payload registers load only on a push and otherwise hold, even after the beat is popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) data_q[k] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = full;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];

`ifdef DEMUX_CNT_EN
  logic [CW-1:0] cnt_q [4];

  // Count accepted beats per channel, wrapping naturally at the counter width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
  assign bus.cnt2 = cnt_q[2];
  assign bus.cnt3 = cnt_q[3];
`else
  assign bus.cnt0 = {CW{1'b0}};
  assign bus.cnt1 = {CW{1'b0}};
  assign bus.cnt2 = {CW{1'b0}};
  assign bus.cnt3 = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Testbench for stream_demux_1to4: directed scenarios plus randomized traffic,
// all checked against a per-channel occupancy/last-value reference model.
module tb_stream_demux_1to4;

  localparam int N  = 32;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  // Reference model: occupancy of each one-entry channel, its last written value, beat counts.
  int          occ      [4];
  logic [31:0] last_val [4];
  int          beats    [4];

  stream_demux_1to4_if #(.N(N), .CW(CW)) bus ();

  stream_demux_1to4 #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dutData(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic logic [CW-1:0] dutCnt(input int k);
    case (k)
      0:       return bus.cnt0;
      1:       return bus.cnt1;
      2:       return bus.cnt2;
      default: return bus.cnt3;
    endcase
  endfunction

  task automatic checkState();
    logic [3:0] expValid;
    logic [CW-1:0] expCnt;
    expValid = '0;
    for (int k = 0; k < 4; k++) expValid[k] = (occ[k] != 0);
    checkOutput("out_valid", 64'(bus.out_valid), 64'(expValid));
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("out_data%0d", k), 64'(dutData(k)), 64'(last_val[k]));
`ifdef DEMUX_CNT_EN
      expCnt = CW'(beats[k] % (1 << CW));
`else
      expCnt = '0;
`endif
      checkOutput($sformatf("cnt%0d", k), 64'(dutCnt(k)), 64'(expCnt));
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic valid, input logic [1:0] sel,
                               input logic [31:0] data, input logic [3:0] rdy,
                               output logic accepted);
    logic expReady;
    @(negedge clk);
    rst_n         = rstn;
    bus.in_valid  = valid;
    bus.in_sel    = sel;
    bus.in_data   = data;
    bus.out_ready = rdy;
    #1;
    expReady = (occ[sel] == 0) || rdy[sel];
    if (valid) checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady));
    accepted = rstn && valid && expReady;
    if (!rstn) begin
      for (int k = 0; k < 4; k++) begin
        occ[k] = 0;
        last_val[k] = '0;
        beats[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (occ[k] != 0 && rdy[k]) occ[k] = 0;
      end
      if (accepted) begin
        occ[sel] = 1;
        last_val[sel] = data;
        beats[sel] = beats[sel] + 1;
      end
    end
    @(posedge clk);
    #1;
    checkState();
  endtask

  initial begin
    logic acc;
    logic pendValid;
    logic [1:0] pendSel;
    logic [31:0] pendData;
    logic [3:0] rdy;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel = 2'd0;
    bus.in_data = '0;
    bus.out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      occ[k] = 0;
      last_val[k] = '0;
      beats[k] = 0;
    end

    // Reset held two cycles with a beat offered: nothing may be captured.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h12345678, 4'b0000, acc);
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h12345678, 4'b0000, acc);
    checkOutput("reset_valid", 64'(bus.out_valid), 64'h0);

    // Single route to ch2 with every consumer stalled, then a blocked second beat.
    applyStimulus(1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, acc);
    checkOutput("route_valid", 64'(bus.out_valid), 64'h4);
    checkOutput("route_data2", 64'(bus.out_data2), 64'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 2'd2, 32'hCAFEF00D, 4'b0000, acc);
    checkOutput("route_blocked", 64'(acc), 64'h0);
    checkOutput("route_hold2", 64'(bus.out_data2), 64'hDEADBEEF);

    // Isolation: ch1 full and stalled must not block a beat to ch3.
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h11111111, 4'b0000, acc);
    applyStimulus(1'b1, 1'b1, 2'd3, 32'h33333333, 4'b0000, acc);
    checkOutput("iso_accept", 64'(acc), 64'h1);
    checkOutput("iso_data1", 64'(bus.out_data1), 64'h11111111);
    checkOutput("iso_data3", 64'(bus.out_data3), 64'h33333333);

    // Back-to-back beats to ch0 with all consumers ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 32'hA0 + 32'(i), 4'b1111, acc);
      checkOutput("b2b_data0", 64'(bus.out_data0), 64'(32'hA0 + 32'(i)));
    end

    // Simultaneous pop and push on ch0 keeps it full with the new value.
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111, acc);
    applyStimulus(1'b1, 1'b1, 2'd0, 32'd5, 4'b0000, acc);
    applyStimulus(1'b1, 1'b1, 2'd0, 32'd6, 4'b0001, acc);
    checkOutput("poppush_valid0", 64'(bus.out_valid[0]), 64'h1);
    checkOutput("poppush_data0", 64'(bus.out_data0), 64'd6);

    // Counter wrap on ch3 after a fresh reset, then reset mid-stream.
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111, acc);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd3, 32'h300 + 32'(i), 4'b1111, acc);
    end
`ifdef DEMUX_CNT_EN
    checkOutput("wrap_cnt3", 64'(bus.cnt3), 64'h1);
`else
    checkOutput("wrap_cnt3", 64'(bus.cnt3), 64'h0);
`endif
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h999, 4'b0000, acc);
    checkOutput("midreset_cnt3", 64'(bus.cnt3), 64'h0);
    checkOutput("midreset_valid", 64'(bus.out_valid), 64'h0);

    // Randomized traffic obeying the producer hold rule.
    pendValid = 1'b0;
    pendSel = 2'd0;
    pendData = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pendValid) begin
        pendValid = ($urandom_range(0, 3) != 0);
        pendSel = 2'($urandom_range(0, 3));
        pendData = $urandom;
      end
      rdy = 4'($urandom);
      applyStimulus(1'b1, pendValid, pendSel, pendData, rdy, acc);
      if (acc) pendValid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
